// File: rtl/topk_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : topk_scheduler_pkg
// Description : Shared FSM state encoding and default sizing constants for
//               the top-K scheduler and its insertion core.
// Revision    : 1.0 - initial release
// ============================================================================
package topk_scheduler_pkg;

    localparam int C_K_DEFAULT  = 8;
    localparam int C_DW_DEFAULT = 32;
    localparam int C_IW_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/topk_insert_core.sv
`default_nettype none
// ============================================================================
// Module      : topk_insert_core
// Description : K-entry sorted slot array. One new score per cycle is placed
//               at the first slot it strictly beats (or the first empty one);
//               everything from that slot on moves down and slot K-1 falls off.
// Revision    : 1.0 - initial release
// ============================================================================
module topk_insert_core
    import topk_scheduler_pkg::*;
#(
    parameter int K  = C_K_DEFAULT,
    parameter int DW = C_DW_DEFAULT,
    parameter int IW = C_IW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 ins_valid,
    input  logic signed [DW-1:0] ins_data,
    input  logic [IW-1:0]        ins_index,
    input  logic                 asce,
    output logic signed [DW-1:0] slot_data  [K],
    output logic [IW-1:0]        slot_index [K],
    output logic [K-1:0]         slot_valid
);

    logic signed [DW-1:0] data_q [K];
    logic signed [DW-1:0] data_d [K];
    logic [IW-1:0]        idx_q  [K];
    logic [IW-1:0]        idx_d  [K];
    logic [K-1:0]         vld_q;
    logic [K-1:0]         vld_d;
    logic [K-1:0]         w_beats;

    // A slot is displaced when empty or strictly beaten; ties lose, so earlier arrivals keep rank.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_beats[i] = !vld_q[i] ||
                         (asce ? (ins_data < data_q[i]) : (ins_data > data_q[i]));
        end
    end

    // Slots are sorted with a valid prefix, so w_beats is monotonic: the first set bit is
    // the insertion point and every later slot takes its upper neighbour.
    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        vld_d  = vld_q;
        if (clear) begin
            vld_d = '0;
        end else if (ins_valid) begin
            if (w_beats[0]) begin
                data_d[0] = ins_data;
                idx_d[0]  = ins_index;
                vld_d[0]  = 1'b1;
            end
            for (int i = 1; i < K; i++) begin
                if (w_beats[i-1]) begin
                    data_d[i] = data_q[i-1];
                    idx_d[i]  = idx_q[i-1];
                    vld_d[i]  = vld_q[i-1];
                end else if (w_beats[i]) begin
                    data_d[i] = ins_data;
                    idx_d[i]  = ins_index;
                    vld_d[i]  = 1'b1;
                end
            end
        end
    end

    // Slot storage; values are zeroed on reset so nothing downstream ever sees X.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) begin
                data_q[i] <= '0;
                idx_q[i]  <= '0;
            end
            vld_q <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
            vld_q  <= vld_d;
        end
    end

    assign slot_data  = data_q;
    assign slot_index = idx_q;
    assign slot_valid = vld_q;

endmodule
`default_nettype wire

// File: rtl/topk_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : topk_scheduler
// Description : Job-based top-K selector. Accepts cfg_len scores on a
//               ready/valid stream, keeps the K best (largest or smallest),
//               then streams them out in rank order with their arrival index.
// Revision    : 1.0 - initial release
// ============================================================================
module topk_scheduler
    import topk_scheduler_pkg::*;
#(
    parameter int K  = C_K_DEFAULT,
    parameter int DW = C_DW_DEFAULT,
    parameter int IW = C_IW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IW-1:0]        cfg_len,
    input  logic                 cfg_asce,
    input  logic                 cfg_relu,
    output logic                 busy,
    output logic                 done,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_data,
    output logic [IW-1:0]        m_index,
    output logic                 m_last
);

    localparam int PW = (K > 1) ? $clog2(K) : 1;

    state_t               state_q, state_d;
    logic [IW-1:0]        len_q, len_d;
    logic                 asce_q, asce_d;
    logic                 relu_q, relu_d;
    logic [IW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        rd_q, rd_d;
    logic                 w_clear;
    logic                 w_ins;
    logic [IW-1:0]        w_nout;
    logic                 w_is_last;
    logic signed [DW-1:0] w_slot_data  [K];
    logic [IW-1:0]        w_slot_index [K];
    logic [K-1:0]         w_slot_valid;
    logic signed [DW-1:0] w_sel_data;

    topk_insert_core #(
        .K  (K),
        .DW (DW),
        .IW (IW)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .ins_valid  (w_ins),
        .ins_data   (s_data),
        .ins_index  (cnt_q),
        .asce       (asce_q),
        .slot_data  (w_slot_data),
        .slot_index (w_slot_index),
        .slot_valid (w_slot_valid)
    );

    // Only min(K, len) slots can ever be filled, and that is exactly how many are emitted.
    assign w_nout     = (len_q < IW'(K)) ? len_q : IW'(K);
    assign w_is_last  = (rd_q == (w_nout - IW'(1)));
    assign w_sel_data = w_slot_data[rd_q[PW-1:0]];
    assign m_data     = (relu_q && w_sel_data[DW-1]) ? '0 : w_sel_data;
    assign m_index    = w_slot_index[rd_q[PW-1:0]];

    // Next-state and handshake outputs; every output defaults low outside its own state.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        asce_d  = asce_q;
        relu_d  = relu_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        busy    = 1'b0;
        done    = 1'b0;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        w_clear = 1'b0;
        w_ins   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    asce_d  = cfg_asce;
                    relu_d  = cfg_relu;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                w_clear = 1'b1;
                cnt_d   = '0;
                rd_d    = '0;
                state_d = (len_q == '0) ? ST_FINISH : ST_LOAD;
            end
            ST_LOAD: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    w_ins = 1'b1;
                    cnt_d = cnt_q + IW'(1);
                    if ((cnt_q + IW'(1)) == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_last  = w_is_last;
                if (m_ready) begin
                    if (w_is_last) begin
                        state_d = ST_FINISH;
                    end else begin
                        rd_d = rd_q + IW'(1);
                    end
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            asce_q  <= 1'b0;
            relu_q  <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            asce_q  <= asce_d;
            relu_q  <= relu_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_topk_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_topk_scheduler
// Description : Self-checking bench for topk_scheduler. Expected outputs are
//               queued when a job is set up and popped on each m_valid/m_ready
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_topk_scheduler;

    localparam int K  = 8;
    localparam int DW = 32;
    localparam int IW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [IW-1:0]        cfg_len;
    logic                 cfg_asce;
    logic                 cfg_relu;
    logic                 busy;
    logic                 done;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW-1:0] m_data;
    logic [IW-1:0]        m_index;
    logic                 m_last;

    typedef struct packed {
        logic signed [DW-1:0] d;
        logic [IW-1:0]        idx;
        logic                 last;
    } exp_t;

    exp_t                 exp_q [$];
    logic signed [DW-1:0] stim_q [$];
    int n_pass  = 0;
    int n_total = 0;

    topk_scheduler #(.K(K), .DW(DW), .IW(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_len  (cfg_len),
        .cfg_asce (cfg_asce),
        .cfg_relu (cfg_relu),
        .busy     (busy),
        .done     (done),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_index  (m_index),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input int d, input int idx, input bit last);
        exp_t e;
        e.d    = DW'(d);
        e.idx  = IW'(idx);
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Runs one job from the current posedge+1 point until done or the cycle budget expires.
    task automatic run_job(input int len, input bit asce, input bit relu,
                           input int gap_pct, input int stall_pct, input bit poke_start,
                           output int sready_cycles);
        int   sent;
        int   cyc;
        int   last_hs_cyc;
        int   exp_done;
        bit   done_seen;
        bit   held;
        exp_t h;
        exp_t e;
        sent = 0; cyc = 0; last_hs_cyc = -1; done_seen = 0; held = 0;
        sready_cycles = 0;
        start = 1'b1; cfg_len = IW'(len); cfg_asce = asce; cfg_relu = relu;
        @(posedge clk); #1;
        start = 1'b0; cfg_len = IW'(1); cfg_asce = ~asce;
        while (!done_seen && cyc < 2000) begin
            s_valid = (sent < len) && ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? stim_q[sent] : DW'($urandom);
            m_ready = ($urandom_range(99) >= stall_pct);
            start   = poke_start && (cyc == 5);
            @(negedge clk);
            if (s_ready) sready_cycles++;
            if (s_valid && s_ready) sent++;
            if (m_valid) begin
                if (held) begin
                    n_total++;
                    if (m_data !== h.d || m_index !== h.idx || m_last !== h.last)
                        $display("FAIL stall_hold: got (%0d,%0d,%0b) required (%0d,%0d,%0b)",
                                 m_data, m_index, m_last, h.d, h.idx, h.last);
                    else n_pass++;
                end
                if (m_ready) begin
                    held = 0;
                    n_total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL extra_output: got (%0d,%0d) required no output", m_data, m_index);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_data !== e.d || m_index !== e.idx || m_last !== e.last)
                            $display("FAIL output: got (%0d,%0d,last=%0b) required (%0d,%0d,last=%0b)",
                                     m_data, m_index, m_last, e.d, e.idx, e.last);
                        else n_pass++;
                    end
                    if (m_last) last_hs_cyc = cyc;
                end else begin
                    held   = 1;
                    h.d    = m_data;
                    h.idx  = m_index;
                    h.last = m_last;
                end
            end
            if (done) begin
                done_seen = 1;
                exp_done  = (len == 0) ? 1 : last_hs_cyc + 1;
                n_total++;
                if (cyc !== exp_done || busy !== 1'b0)
                    $display("FAIL done_timing: got cycle %0d busy %0b required cycle %0d busy 0",
                             cyc, busy, exp_done);
                else n_pass++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        n_total++;
        if (!done_seen) $display("FAIL job_timeout: got no done required done within 2000 cycles");
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL missing_outputs: got %0d left required 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
        stim_q.delete();
    endtask

    task automatic load_main_stream();
        int s [10] = '{5, -3, 9, 9, 0, 7, 1, 2, -8, 4};
        foreach (s[i]) stim_q.push_back(DW'(s[i]));
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; cfg_len = '0; cfg_asce = 1'b0; cfg_relu = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({busy, done, s_ready, m_valid, m_last} !== 5'b0)
            $display("FAIL reset_outputs: got %b required 00000", {busy, done, s_ready, m_valid, m_last});
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({busy, done, s_ready, m_valid} !== 4'b0)
            $display("FAIL idle_after_reset: got %b required 0000", {busy, done, s_ready, m_valid});
        else n_pass++;
    endtask

    task automatic test_desc();
        int sr;
        load_main_stream();
        push_exp(9, 2, 0); push_exp(9, 3, 0); push_exp(7, 5, 0); push_exp(5, 0, 0);
        push_exp(4, 9, 0); push_exp(2, 7, 0); push_exp(1, 6, 0); push_exp(0, 4, 1);
        run_job(10, 0, 0, 0, 0, 0, sr);
    endtask

    task automatic test_asce_relu();
        int sr;
        load_main_stream();
        push_exp(0, 8, 0); push_exp(0, 1, 0); push_exp(0, 4, 0); push_exp(1, 6, 0);
        push_exp(2, 7, 0); push_exp(4, 9, 0); push_exp(5, 0, 0); push_exp(7, 5, 1);
        run_job(10, 1, 1, 0, 0, 0, sr);
    endtask

    task automatic test_short();
        int sr;
        stim_q.push_back(DW'(1)); stim_q.push_back(DW'(2)); stim_q.push_back(DW'(3));
        push_exp(3, 2, 0); push_exp(2, 1, 0); push_exp(1, 0, 1);
        run_job(3, 0, 0, 0, 0, 0, sr);
    endtask

    task automatic test_len0();
        int sr;
        run_job(0, 0, 0, 0, 0, 0, sr);
        n_total++;
        if (sr !== 0) $display("FAIL len0_sready: got %0d ready cycles required 0", sr);
        else n_pass++;
    endtask

    task automatic test_stalls();
        int sr;
        load_main_stream();
        push_exp(9, 2, 0); push_exp(9, 3, 0); push_exp(7, 5, 0); push_exp(5, 0, 0);
        push_exp(4, 9, 0); push_exp(2, 7, 0); push_exp(1, 6, 0); push_exp(0, 4, 1);
        run_job(10, 0, 0, 35, 45, 1, sr);
    endtask

    // Reference: repeatedly pick the best unused score, earliest index on ties.
    task automatic test_random_model();
        int  sr;
        int  len;
        int  nout;
        int  best;
        bit  asce;
        int  v [13];
        bit  used [13];
        len  = 13;
        asce = 1'($urandom_range(1));
        for (int i = 0; i < len; i++) begin
            v[i]    = int'($urandom_range(40)) - 20;
            used[i] = 0;
            stim_q.push_back(DW'(v[i]));
        end
        nout = (len < K) ? len : K;
        for (int r = 0; r < nout; r++) begin
            best = -1;
            for (int j = 0; j < len; j++) begin
                if (!used[j] && (best < 0 || (asce ? (v[j] < v[best]) : (v[j] > v[best]))))
                    best = j;
            end
            used[best] = 1;
            push_exp(v[best], best, r == nout - 1);
        end
        run_job(len, asce, 0, 20, 20, 0, sr);
    endtask

    task automatic test_reset_midjob();
        int sr;
        int got;
        int cyc;
        got = 0; cyc = 0;
        start = 1'b1; cfg_len = IW'(10); cfg_asce = 1'b0; cfg_relu = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (got < 4 && cyc < 50) begin
            s_valid = 1'b1;
            s_data  = DW'(got + 10);
            @(negedge clk);
            if (s_ready) got++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({busy, done, s_ready, m_valid, m_last} !== 5'b0)
            $display("FAIL midjob_reset: got %b required 00000", {busy, done, s_ready, m_valid, m_last});
        else n_pass++;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_total++;
            if ({busy, done, m_valid} !== 3'b0)
                $display("FAIL abandoned_job: got %b required 000", {busy, done, m_valid});
            else n_pass++;
            @(posedge clk); #1;
        end
        stim_q.push_back(DW'(6)); stim_q.push_back(-DW'(1));
        push_exp(6, 0, 0); push_exp(-1, 1, 1);
        run_job(2, 0, 0, 0, 0, 0, sr);
    endtask

    initial begin
        test_reset();
        test_desc();
        test_asce_relu();
        test_short();
        test_len0();
        test_stalls();
        test_random_model();
        test_reset_midjob();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/topk_scheduler.md
TOPK_SCHEDULER -- requirements
Module: topk_scheduler

Interface
REQ-001 SHALL have parameter K, 8, number of retained best entries (K >= 1).
REQ-002 SHALL have parameter DW, 32, score data width (signed two's complement).
REQ-003 SHALL have parameter IW, 32, index width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle job launch request.
REQ-007 SHALL have port cfg_len  input  IW  number of scores in the job, sampled at accepted start.
REQ-008 SHALL have port cfg_asce  input  1  1 = keep K smallest in ascending order; 0 = keep K largest in descending order; sampled at accepted start.
REQ-009 SHALL have port cfg_relu  input  1  1 = clamp negative output scores to 0; sampled at accepted start.
REQ-010 SHALL have port busy  output  1  high from accepted start until done.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports s_valid input 1, s_ready output 1, s_data input DW  score input stream.
REQ-013 SHALL have ports m_valid output 1, m_ready input 1, m_data output DW, m_index output IW, m_last output 1  result stream.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, LOAD, DRAIN, FINISH.
REQ-015 IDLE: start=1 SHALL latch cfg_* and go to CLEAR; start while busy SHALL be ignored.
REQ-016 CLEAR: SHALL clear all K slot-valid bits and the index counter in one cycle, then go to LOAD, or to FINISH when latched cfg_len==0.
REQ-017 LOAD: s_ready SHALL be 1; s_ready SHALL be 0 in every other state.
REQ-018 Each s_valid&s_ready handshake SHALL insert s_data with index = count of scores previously accepted in the job (0-based).
REQ-019 Insertion SHALL complete in the cycle of the handshake; the sorted slots SHALL be updated at the following edge, sustaining one score per cycle.
REQ-020 Insertion position SHALL be the first slot that is invalid or whose value the new score beats strictly (cfg_asce=1: less-than; 0: greater-than), signed comparison.
REQ-021 Entries at and after the insertion position SHALL shift down one slot; slot K-1 SHALL be discarded; a score that beats no slot while all K are valid SHALL be dropped.
REQ-022 Equal scores SHALL keep arrival order (earlier index ranks first).
REQ-023 After the cfg_len-th handshake the FSM SHALL enter DRAIN on the next edge.
REQ-024 DRAIN SHALL emit valid slots 0 .. min(K,cfg_len)-1 in order, m_valid high from the first DRAIN cycle.
REQ-025 m_data/m_index/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-026 m_last SHALL be 1 only on the final emitted entry.
REQ-027 With cfg_relu=1, m_data SHALL be 0 when the stored score is negative; ranking SHALL always use unclamped scores.
REQ-028 After the m_last handshake the FSM SHALL enter FINISH; FINISH SHALL pulse done for one cycle, deassert busy, and return to IDLE.
REQ-029 Slot values SHALL never be X-dependent; validity SHALL be tracked by explicit per-slot valid bits.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE, busy=0, done=0, s_ready=0, m_valid=0, m_last=0, all slot-valid bits 0, index counter 0, regardless of current state.
REQ-031 A job interrupted by reset SHALL be abandoned; no outputs or done SHALL follow.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and default K/DW/IW constants.
REQ-033 The sorted-slot array and insertion/shift logic SHALL be a sub-module topk_insert_core (inputs: clear, ins_valid, ins_data, ins_index, asce; outputs: slot arrays and valid bits).

Verification
REQ-034 K=8, asce=0, len=10, scores 5,-3,9,9,0,7,1,2,-8,4 -> outputs (9,2),(9,3),(7,5),(5,0),(4,9),(2,7),(1,6),(0,4); m_last on 8th; done one cycle later.
REQ-035 Same stream, asce=1, relu=1 -> outputs data 0,0,0,1,2,4,5,7 with indices 8,1,4,6,7,9,0,5.
REQ-036 len=3, asce=0, scores 1,2,3 -> exactly 3 outputs (3,2),(2,1),(1,0), m_last on third.
REQ-037 len=0 -> no s_ready, no m_valid, done pulses 2 cycles after start.
REQ-038 Random s_valid gaps and m_ready stalls on REQ-034 stream -> identical outputs, outputs stable during stalls, start during busy ignored.
REQ-039 rst=0 asserted during LOAD after 4 scores -> all outputs at reset values next cycle; subsequent job with len=2 (6,-1) -> (6,0),(-1,1) only.
